ysyx_22040750_dmem_resp: RTL and testbench

Data-memory responder for the pipeline's MEM stage. Accepts one load or store request per handshake from the EX/MEM register's `mem_rd_en`/`mem_wr_en`/`mem_ready` interface and drives a synchronous single-port data SRAM with configurable read latency. It returns a one-cycle `rvalid` pulse with the aligned, masked and sign-extended load data, or a one-cycle `bvalid` pulse for a completed store.

---
 rtl/ysyx_22040750_dmem_resp_pkg.sv | 27 ++
 rtl/ysyx_22040750_load_align.sv | 39 +++
 rtl/ysyx_22040750_dmem_resp.sv | 147 ++++++++++++++
 tb/tb_ysyx_22040750_dmem_resp.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040750_dmem_resp_pkg.sv
// rtl/ysyx_22040750_dmem_resp_pkg.sv - shared state encodings and size masks for the MEM-stage data responder
// Contents: dmem_state_t (2-bit FSM encoding), STRB_B/H/W/D size masks,
//           byte_expand() turning an 8-bit byte mask into a 64-bit bit mask.
package ysyx_22040750_dmem_resp_pkg;

   typedef enum logic [1:0] {
      DMEM_IDLE   = 2'd0,
      DMEM_ACCESS = 2'd1,
      DMEM_WAIT   = 2'd2,
      DMEM_RESP   = 2'd3
   } dmem_state_t;

   localparam logic [7:0] STRB_B = 8'h01;
   localparam logic [7:0] STRB_H = 8'h03;
   localparam logic [7:0] STRB_W = 8'h0F;
   localparam logic [7:0] STRB_D = 8'hFF;

   function automatic logic [63:0] byte_expand(input logic [7:0] i_mask);
      logic [63:0] r_bits;
      r_bits = '0;
      for (int i = 0; i < 8; i++) begin
         r_bits[8*i +: 8] = {8{i_mask[i]}};
      end
      return r_bits;
   endfunction

endpackage

// File: rtl/ysyx_22040750_load_align.sv
// rtl/ysyx_22040750_load_align.sv - combinational load-data shift, size mask and sign extension
// Ports: i_rdata  raw 64-bit SRAM word
//        i_off    byte offset of the load inside the word
//        i_rstrb  [7:0] right-justified size mask, [8] sign-extend enable
//        o_data   right-justified, masked and optionally sign-extended result
module ysyx_22040750_load_align
   import ysyx_22040750_dmem_resp_pkg::*;
(
   input  logic [63:0] i_rdata,
   input  logic [2:0]  i_off,
   input  logic [8:0]  i_rstrb,
   output logic [63:0] o_data
);

   logic [63:0] w_shifted;
   logic [63:0] w_mask;
   logic [63:0] w_masked;
   logic [2:0]  w_top;
   logic        w_sign;

   // Bytes above lane 7 shift in as zero, so word-crossing loads come back truncated.
   assign w_shifted = i_rdata >> {i_off, 3'b000};
   assign w_mask    = byte_expand(i_rstrb[7:0]);
   assign w_masked  = w_shifted & w_mask;

   // Sign bit lives in the highest byte selected by the size mask.
   always_comb begin
      w_top = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (i_rstrb[i]) begin
            w_top = 3'(i);
         end
      end
   end

   assign w_sign = i_rstrb[8] & w_masked[{w_top, 3'b111}];
   assign o_data = w_sign ? (w_masked | ~w_mask) : w_masked;

endmodule

// File: rtl/ysyx_22040750_dmem_resp.sv
// rtl/ysyx_22040750_dmem_resp.sv - MEM-stage load/store responder driving a synchronous data SRAM
// Ports: I_sys_clk/I_rst             clock, synchronous active-high reset
//        I_mem_rd_en/I_mem_wr_en     held request, accepted when O_mem_ready is high
//        I_addr/I_wdata/I_wstrb/I_rstrb  request fields, latched at the handshake
//        O_mem_data_rvalid/O_rdata   one-cycle load response, O_rdata held until next load
//        O_mem_data_bvalid           one-cycle store completion
//        O_sram_*/I_sram_rdata       single-port SRAM, read data valid LATENCY cycles after enable
module ysyx_22040750_dmem_resp
   import ysyx_22040750_dmem_resp_pkg::*;
#(
   parameter int LATENCY = 1,
   parameter int ADDR_W  = 16
) (
   input  logic              I_sys_clk,
   input  logic              I_rst,
   input  logic              I_mem_rd_en,
   input  logic              I_mem_wr_en,
   input  logic [63:0]       I_addr,
   input  logic [63:0]       I_wdata,
   input  logic [7:0]        I_wstrb,
   input  logic [8:0]        I_rstrb,
   output logic              O_mem_ready,
   output logic              O_mem_data_rvalid,
   output logic              O_mem_data_bvalid,
   output logic [63:0]       O_rdata,
   output logic              O_sram_en,
   output logic              O_sram_we,
   output logic [ADDR_W-1:0] O_sram_addr,
   output logic [63:0]       O_sram_wdata,
   output logic [7:0]        O_sram_wmask,
   input  logic [63:0]       I_sram_rdata
);

   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

   dmem_state_t       r_state;
   dmem_state_t       w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_is_wr;
   logic [ADDR_W-1:0] r_addr;
   logic [2:0]        r_off;
   logic [8:0]        r_rstrb;
   logic [63:0]       r_wdata;
   logic [7:0]        r_wmask;
   logic [63:0]       r_rdata;

   logic              w_req;
   logic              w_fire;
   logic              w_ready;
   logic              w_access;
   logic              w_rvalid;
   logic              w_bvalid;
   logic              w_capture;
   logic [63:0]       w_align;
   logic              w_unused;

   assign w_req     = I_mem_rd_en | I_mem_wr_en;
   assign w_fire    = (r_state == DMEM_IDLE) & w_req;
   assign w_capture = (r_state == DMEM_WAIT) & (r_cnt == '0);
   assign w_unused  = ^I_addr[63:ADDR_W+3];

   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      w_access    = 1'b0;
      w_rvalid    = 1'b0;
      w_bvalid    = 1'b0;
      case (r_state)
         DMEM_IDLE: begin
            w_ready = 1'b1;
            if (w_req) w_state_nxt = DMEM_ACCESS;
         end
         DMEM_ACCESS: begin
            w_access    = 1'b1;
            w_state_nxt = r_is_wr ? DMEM_RESP : DMEM_WAIT;
         end
         DMEM_WAIT: begin
            if (r_cnt == '0) w_state_nxt = DMEM_RESP;
         end
         DMEM_RESP: begin
            w_rvalid    = ~r_is_wr;
            w_bvalid    = r_is_wr;
            w_state_nxt = DMEM_IDLE;
         end
         default: w_state_nxt = DMEM_IDLE;
      endcase
   end

   always_ff @(posedge I_sys_clk) begin
      if (I_rst) begin
         r_state <= DMEM_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge I_sys_clk) begin
      if (I_rst) begin
         r_cnt   <= '0;
         r_is_wr <= 1'b0;
         r_addr  <= '0;
         r_off   <= '0;
         r_rstrb <= '0;
         r_wdata <= '0;
         r_wmask <= '0;
         r_rdata <= '0;
      end else begin
         if (w_fire) begin
            // A simultaneous rd_en/wr_en resolves to a store.
            r_is_wr <= I_mem_wr_en;
            r_addr  <= I_addr[ADDR_W+2:3];
            r_off   <= I_addr[2:0];
            r_rstrb <= I_rstrb;
            r_wdata <= I_wdata << {I_addr[2:0], 3'b000};
            r_wmask <= I_wstrb << I_addr[2:0];
         end
         if (r_state == DMEM_ACCESS) begin
            r_cnt <= CNT_INIT;
         end else if ((r_state == DMEM_WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
         if (w_capture) begin
            r_rdata <= w_align;
         end
      end
   end

   ysyx_22040750_load_align u_load_align (
      .i_rdata (I_sram_rdata),
      .i_off   (r_off),
      .i_rstrb (r_rstrb),
      .o_data  (w_align)
   );

   // Reset gates every output so an in-flight write or response is dropped in the reset cycle itself.
   assign O_mem_ready       = w_ready  & ~I_rst;
   assign O_mem_data_rvalid = w_rvalid & ~I_rst;
   assign O_mem_data_bvalid = w_bvalid & ~I_rst;
   assign O_sram_en         = w_access & ~I_rst;
   assign O_sram_we         = w_access & r_is_wr & ~I_rst;
   assign O_sram_addr       = I_rst ? '0 : r_addr;
   assign O_sram_wdata      = I_rst ? '0 : r_wdata;
   assign O_sram_wmask      = I_rst ? '0 : r_wmask;
   assign O_rdata           = I_rst ? '0 : r_rdata;

endmodule

// File: tb/tb_ysyx_22040750_dmem_resp.sv
// tb/tb_ysyx_22040750_dmem_resp.sv - self-checking bench for the MEM-stage data responder
module tb_ysyx_22040750_dmem_resp;
   import ysyx_22040750_dmem_resp_pkg::*;

   localparam int LAT    = 2;
   localparam int ADDR_W = 16;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [7:0]  wstrb;
      logic [8:0]  rstrb;
   } req_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              rd_en, wr_en;
   logic [63:0]       addr, wdata;
   logic [7:0]        wstrb;
   logic [8:0]        rstrb;
   logic              ready, rvalid, bvalid;
   logic [63:0]       rdata;
   logic              sram_en, sram_we;
   logic [ADDR_W-1:0] sram_addr;
   logic [63:0]       sram_wdata;
   logic [7:0]        sram_wmask;
   logic [63:0]       sram_rdata;

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [7:0]  ref_mem [0:63][0:7];
   logic [63:0] exp_rdata;

   always #5 clk = ~clk;

   ysyx_22040750_dmem_resp #(.LATENCY(LAT), .ADDR_W(ADDR_W)) dut (
      .I_sys_clk         (clk),
      .I_rst             (rst),
      .I_mem_rd_en       (rd_en),
      .I_mem_wr_en       (wr_en),
      .I_addr            (addr),
      .I_wdata           (wdata),
      .I_wstrb           (wstrb),
      .I_rstrb           (rstrb),
      .O_mem_ready       (ready),
      .O_mem_data_rvalid (rvalid),
      .O_mem_data_bvalid (bvalid),
      .O_rdata           (rdata),
      .O_sram_en         (sram_en),
      .O_sram_we         (sram_we),
      .O_sram_addr       (sram_addr),
      .O_sram_wdata      (sram_wdata),
      .O_sram_wmask      (sram_wmask),
      .I_sram_rdata      (sram_rdata)
   );

   // SRAM with a two-stage read pipeline; idle cycles inject noise so mistimed captures show up.
   logic [63:0] sram_mem [0:63];
   logic [63:0] rd_p0, rd_p1;
   always @(posedge clk) begin
      if (sram_en && !sram_we) rd_p0 <= sram_mem[sram_addr[5:0]];
      else                     rd_p0 <= {$urandom, $urandom};
      rd_p1 <= rd_p0;
      if (sram_en && sram_we) begin
         for (int b = 0; b < 8; b++) begin
            if (sram_wmask[b]) sram_mem[sram_addr[5:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
         end
      end
   end
   assign sram_rdata = rd_p1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%016h expected=0x%016h", tag, obs, exp);
      end
   endtask

   task automatic drive(input req_t r);
      rd_en = r.rd; wr_en = r.wr; addr = r.addr;
      wdata = r.wdata; wstrb = r.wstrb; rstrb = r.rstrb;
   endtask

   function automatic logic [7:0] rand_size();
      case ($urandom_range(0, 3))
         0:       return STRB_B;
         1:       return STRB_H;
         2:       return STRB_W;
         default: return STRB_D;
      endcase
   endfunction

   function automatic req_t mk_req(input logic rd, input logic wr, input logic [63:0] a,
                                   input logic [63:0] d, input logic [7:0] ws, input logic [8:0] rs);
      req_t r;
      r.rd = rd; r.wr = wr; r.addr = a; r.wdata = d; r.wstrb = ws; r.rstrb = rs;
      return r;
   endfunction

   function automatic req_t junk();
      return mk_req(1'b0, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom), 9'($urandom));
   endfunction

   // Byte-level view of a load: pick size bytes starting at the offset, zero past lane 7, extend sign.
   function automatic logic [63:0] ref_load(input logic [5:0] w, input logic [2:0] off, input logic [8:0] rs);
      logic [63:0] v = '0;
      int          n = 0;
      for (int b = 0; b < 8; b++) begin
         if (rs[b]) begin
            if (int'(off) + b < 8) v[8*b +: 8] = ref_mem[w][int'(off) + b];
            n = b + 1;
         end
      end
      if (rs[8] && n > 0 && v[8*n-1]) begin
         for (int b = n; b < 8; b++) v[8*b +: 8] = 8'hFF;
      end
      return v;
   endfunction

   // One transaction from handshake to the cycle after its response; nxt is driven after acceptance.
   task automatic run_txn(input req_t nxt, input int exp_wait);
      req_t        cur;
      int          waited;
      logic        is_wr;
      logic [2:0]  off;
      logic [5:0]  w;
      logic [63:0] ewd, eld;
      logic [7:0]  ewm;
      cur = mk_req(rd_en, wr_en, addr, wdata, wstrb, rstrb);
      waited = 0;
      while (ready !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (exp_wait >= 0) check("hs_wait", 64'(waited), 64'(exp_wait));
      else               check("hs_ready", {63'd0, ready}, 64'd1);
      is_wr = cur.wr;
      off   = cur.addr[2:0];
      w     = cur.addr[8:3];
      @(negedge clk);
      drive(nxt);
      #1;
      check("acc_en", {63'd0, sram_en}, 64'd1);
      check("acc_we", {63'd0, sram_we}, {63'd0, is_wr});
      check("acc_addr", 64'(sram_addr), 64'(cur.addr[ADDR_W+2:3]));
      check("acc_ready", {63'd0, ready}, 64'd0);
      eld = '0;
      if (is_wr) begin
         ewd = '0; ewm = '0;
         for (int b = 0; b + int'(off) < 8; b++) begin
            ewd[8*(b + int'(off)) +: 8] = cur.wdata[8*b +: 8];
            if (cur.wstrb[b]) begin
               ewm[b + int'(off)] = 1'b1;
               ref_mem[w][b + int'(off)] = cur.wdata[8*b +: 8];
            end
         end
         check("acc_wdata", sram_wdata, ewd);
         check("acc_wmask", 64'(sram_wmask), 64'(ewm));
      end else begin
         eld = ref_load(w, off, cur.rstrb);
         for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            check("wait_rvalid", {63'd0, rvalid}, 64'd0);
            check("wait_en", {63'd0, sram_en}, 64'd0);
            check("wait_ready", {63'd0, ready}, 64'd0);
         end
      end
      @(negedge clk);
      check("resp_rvalid", {63'd0, rvalid}, {63'd0, ~is_wr});
      check("resp_bvalid", {63'd0, bvalid}, {63'd0, is_wr});
      check("resp_en", {63'd0, sram_en}, 64'd0);
      if (!is_wr) exp_rdata = eld;
      check("resp_rdata", rdata, exp_rdata);
      @(negedge clk);
      check("post_rvalid", {63'd0, rvalid}, 64'd0);
      check("post_bvalid", {63'd0, bvalid}, 64'd0);
      check("post_ready", {63'd0, ready}, 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      req_t r;
      int   waited;
      exp_rdata = '0;
      for (int i = 0; i < 64; i++) for (int j = 0; j < 8; j++) ref_mem[i][j] = 8'h00;

      // Reset held for three cycles.
      rst = 1'b1;
      drive(mk_req(1'b0, 1'b0, 64'd0, 64'd0, 8'd0, 9'd0));
      repeat (3) begin
         @(negedge clk);
         check("rst_ready", {63'd0, ready}, 64'd0);
         check("rst_rvalid", {63'd0, rvalid}, 64'd0);
         check("rst_bvalid", {63'd0, bvalid}, 64'd0);
         check("rst_en", {63'd0, sram_en}, 64'd0);
         check("rst_we", {63'd0, sram_we}, 64'd0);
         check("rst_rdata", rdata, 64'd0);
         check("rst_addr", 64'(sram_addr), 64'd0);
         check("rst_wdata", sram_wdata, 64'd0);
         check("rst_wmask", 64'(sram_wmask), 64'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      check("rel_ready", {63'd0, ready}, 64'd1);

      // Fill every modelled word with full-width stores, back to back.
      for (int i = 0; i < 64; i++) begin
         drive(mk_req(1'b0, 1'b1, 64'(i) << 3, {$urandom, $urandom}, STRB_D, 9'd0));
         run_txn(junk(), 0);
      end

      // Byte store at offset 5.
      drive(mk_req(1'b0, 1'b1, 64'h8000_0005, 64'hAB, STRB_B, 9'd0));
      run_txn(junk(), 0);

      // Signed half load from the top of 0x8001_0000_0000_0000.
      drive(mk_req(1'b0, 1'b1, 64'h10, 64'h8001_0000_0000_0000, STRB_D, 9'd0));
      run_txn(junk(), 0);
      drive(mk_req(1'b1, 1'b0, 64'h16, {$urandom, $urandom}, 8'd0, 9'h103));
      run_txn(junk(), 0);
      check("half_signed", rdata, 64'hFFFF_FFFF_FFFF_8001);

      // Unsigned word load at offset 4, then a store must leave O_rdata alone.
      drive(mk_req(1'b1, 1'b0, 64'h14, 64'd0, 8'd0, 9'h00F));
      run_txn(junk(), 0);
      check("word_unsigned", rdata, 64'h0000_0000_8001_0000);
      drive(mk_req(1'b0, 1'b1, 64'h38, {$urandom, $urandom}, STRB_W, 9'd0));
      run_txn(junk(), 0);
      check("rdata_hold", rdata, 64'h0000_0000_8001_0000);

      // Second load held high through the whole first transaction.
      drive(mk_req(1'b1, 1'b0, 64'h10, 64'd0, 8'd0, 9'h1FF));
      run_txn(mk_req(1'b1, 1'b0, 64'h23, {$urandom, $urandom}, 8'd0, 9'h103), 0);
      run_txn(junk(), 0);

      // Reset landing in the WAIT cycle of a load.
      drive(mk_req(1'b1, 1'b0, 64'h16, 64'd0, 8'd0, 9'h103));
      waited = 0;
      while (ready !== 1'b1 && waited < 20) begin @(negedge clk); waited++; end
      check("abort_hs", 64'(waited), 64'd0);
      @(negedge clk);
      drive(junk());
      #1;
      check("abort_acc_en", {63'd0, sram_en}, 64'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_rvalid0", {63'd0, rvalid}, 64'd0);
      check("abort_ready0", {63'd0, ready}, 64'd0);
      @(negedge clk);
      check("abort_rvalid1", {63'd0, rvalid}, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("abort_rvalid2", {63'd0, rvalid}, 64'd0);
      check("abort_ready", {63'd0, ready}, 64'd1);
      exp_rdata = '0;
      check("abort_rdata", rdata, exp_rdata);
      drive(mk_req(1'b1, 1'b1, 64'h2A, {$urandom, $urandom}, STRB_H, 9'h1FF));
      run_txn(junk(), 0);

      // Reset landing in the ACCESS cycle of a store suppresses the write.
      drive(mk_req(1'b0, 1'b1, 64'h28, 64'hDEAD_BEEF_0BAD_F00D, STRB_D, 9'd0));
      waited = 0;
      while (ready !== 1'b1 && waited < 20) begin @(negedge clk); waited++; end
      check("supp_hs", 64'(waited), 64'd0);
      @(negedge clk);
      drive(junk());
      rst = 1'b1;
      #1;
      check("supp_en", {63'd0, sram_en}, 64'd0);
      check("supp_we", {63'd0, sram_we}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("supp_bvalid", {63'd0, bvalid}, 64'd0);
      check("supp_ready", {63'd0, ready}, 64'd1);
      drive(mk_req(1'b1, 1'b0, 64'h28, 64'd0, 8'd0, 9'h0FF));
      run_txn(junk(), 0);

      // Random mix of loads and stores across offsets, sizes and signedness.
      for (int i = 0; i < 60; i++) begin
         r.wr    = ($urandom_range(0, 1) == 1);
         r.rd    = r.wr ? ($urandom_range(0, 3) == 0) : 1'b1;
         r.addr  = {$urandom, 32'd0} | 64'($urandom_range(0, 511));
         r.wdata = {$urandom, $urandom};
         r.wstrb = rand_size();
         r.rstrb = {1'($urandom_range(0, 1)), rand_size()};
         drive(r);
         run_txn(junk(), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
